// File: rtl/pid_sequencer_pkg.sv
// Shared types and saturation helpers for the pid sample-rate sequencer.
// The DAC code is offset-binary, so the signed clamp range is centred on mid-scale.
package pid_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADC_WAIT,
    STEP,
    DAC_WAIT
  } state_t;

  localparam int WIDTH_DEF = 18;
  localparam int DAC_W_DEF = 12;

  // Signed clamp bounds for a DAC of the given width.
  function automatic int sat_hi(input int dac_w);
    return (1 << (dac_w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int dac_w);
    return -(1 << (dac_w - 1));
  endfunction

endpackage

// File: rtl/pid_sequencer_sat_offset.sv
// Combinational clamp of the signed controller output into the DAC range,
// followed by the mid-scale offset that turns two's complement into offset-binary.
module sat_offset
  import pid_seq_pkg::*;
#(
  parameter int Width = WIDTH_DEF,
  parameter int DAC_W = DAC_W_DEF
) (
  input  logic signed [Width-1:0] u,
  output logic        [DAC_W-1:0] code
);

  localparam logic signed [Width-1:0] HI  = Width'(sat_hi(DAC_W));
  localparam logic signed [Width-1:0] LO  = Width'(sat_lo(DAC_W));
  localparam logic        [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

  // Comparison happens at full width so large inputs never wrap into range.
  function automatic logic [DAC_W-1:0] clamp_offset(input logic signed [Width-1:0] v);
    logic signed [Width-1:0] s;
    if (v > HI)
      s = HI;
    else if (v < LO)
      s = LO;
    else
      s = v;
    return s[DAC_W-1:0] + MID;
  endfunction

  assign code = clamp_offset(u);

endmodule

// File: rtl/pid_sequencer.sv
// Sample-rate controller around the pid datapath: sample tick, ADC req/ack fetch,
// single-cycle pid enable, output saturation and DAC valid/ready hand-off.
module pid_sequencer
  import pid_seq_pkg::*;
#(
  parameter int Width = WIDTH_DEF,
  parameter int DAC_W = DAC_W_DEF,
  parameter int DIV   = 1000,
  parameter int TMO   = 255
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    run,
  input  logic signed [Width-1:0] rk_in,
  output logic                    adc_req,
  input  logic                    adc_ack,
  input  logic signed [Width-1:0] adc_data,
  output logic signed [Width-1:0] pid_yk,
  output logic signed [Width-1:0] pid_rk,
  output logic                    pid_en,
  output logic                    pid_clr,
  input  logic signed [Width-1:0] pid_u,
  output logic                    dac_valid,
  input  logic                    dac_ready,
  output logic        [DAC_W-1:0] dac_data,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

  state_t          state;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [TW-1:0]   wait_cnt;
  logic            run_p1;
  logic            run_rise;
  logic [DAC_W-1:0] sat_code;

  sat_offset #(
    .Width (Width),
    .DAC_W (DAC_W)
  ) u_sat (
    .u    (pid_u),
    .code (sat_code)
  );

  // Sample-period divider: stopped and cleared whenever sampling is disabled.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst)
      tick_cnt <= '0;
    else if (!run || tick_cnt == CW'(DIV - 1))
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CW'(1);
  end

  assign tick = run && (tick_cnt == CW'(DIV - 1));

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst)
      run_p1 <= 1'b0;
    else
      run_p1 <= run;
  end

  assign run_rise = run && !run_p1;
  assign busy     = (state != IDLE);

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      adc_req   <= 1'b0;
      pid_yk    <= '0;
      pid_rk    <= '0;
      pid_en    <= 1'b0;
      pid_clr   <= 1'b0;
      dac_valid <= 1'b0;
      dac_data  <= MID;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      pid_en  <= 1'b0;
      pid_clr <= run_rise;

      // Ticks that land mid-sample are dropped; only the flag records them.
      if (run_rise) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end else if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            pid_rk   <= rk_in;
            adc_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= ADC_WAIT;
          end
        end

        // An ack arriving on the expiry cycle still completes the sample.
        ADC_WAIT: begin
          if (adc_ack) begin
            pid_yk  <= adc_data;
            adc_req <= 1'b0;
            pid_en  <= 1'b1;
            state   <= STEP;
          end else if (wait_cnt == TW'(TMO - 1)) begin
            adc_req <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        // pid_u still reflects the pre-update pid state during the enable cycle.
        STEP: begin
          dac_data  <= sat_code;
          dac_valid <= 1'b1;
          state     <= DAC_WAIT;
        end

        DAC_WAIT: begin
          if (dac_ready) begin
            dac_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed scoreboard bench for pid_sequencer: an ADC responder queues the expected DAC
// code for every ack it issues, and an independent monitor checks each accepted DAC word.
module tb_pid_sequencer;

  localparam int W   = 18;
  localparam int DW  = 12;
  localparam int DIV = 16;
  localparam int TMO = 255;

  logic                sclk = 1'b0;
  logic                rst  = 1'b0;
  logic                run  = 1'b0;
  logic signed [W-1:0] rk_in = W'(500);
  logic                adc_req;
  logic                adc_ack = 1'b0;
  logic signed [W-1:0] adc_data = '0;
  logic signed [W-1:0] pid_yk;
  logic signed [W-1:0] pid_rk;
  logic                pid_en;
  logic                pid_clr;
  logic signed [W-1:0] pid_u;
  logic                dac_valid;
  logic                dac_ready = 1'b1;
  logic [DW-1:0]       dac_data;
  logic                busy;
  logic                overrun;
  logic                timeout;

  int n_chk  = 0;
  int n_fail = 0;
  int hs_count = 0;
  int en_count = 0;
  int q[$];

  bit ack_en     = 1'b1;
  int ack_delay  = 3;
  int yk_tab[4]  = '{100, 300, 600, -200};
  int yk_idx     = 0;
  int rsp_yk     = 0;
  bit force_en   = 1'b0;
  int force_val  = 0;
  bit period_chk = 1'b0;
  int force_tab[7] = '{131071, -131072, -5, 2047, 2048, -2048, -2049};

  always #5 sclk = ~sclk;

  // Stand-in for the pid instance: combinational on its registered inputs.
  assign pid_u = force_en ? W'(force_val) : W'(3 * (int'(pid_rk) - int'(pid_yk)));

  pid_sequencer #(
    .Width (W),
    .DAC_W (DW),
    .DIV   (DIV),
    .TMO   (TMO)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .run       (run),
    .rk_in     (rk_in),
    .adc_req   (adc_req),
    .adc_ack   (adc_ack),
    .adc_data  (adc_data),
    .pid_yk    (pid_yk),
    .pid_rk    (pid_rk),
    .pid_en    (pid_en),
    .pid_clr   (pid_clr),
    .pid_u     (pid_u),
    .dac_valid (dac_valid),
    .dac_ready (dac_ready),
    .dac_data  (dac_data),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  function automatic int exp_code(input int u);
    if (u > 2047) return 4095;
    if (u < -2048) return 0;
    return u + 2048;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_hs(input int budget);
    int start;
    int n;
    start = hs_count;
    n = 0;
    while (hs_count == start && n < budget) begin
      @(negedge sclk);
      n++;
    end
    if (hs_count == start) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_hs: no DAC handshake within %0d cycles", budget);
    end
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!adc_req && n < budget) begin
      @(negedge sclk);
      n++;
    end
    if (!adc_req) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_req: adc_req not raised within %0d cycles", budget);
    end
  endtask

  task automatic wait_en(input int budget);
    int n;
    n = 0;
    while (!pid_en && n < budget) begin
      @(negedge sclk);
      n++;
    end
    if (!pid_en) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_en: pid_en not seen within %0d cycles", budget);
    end
  endtask

  // ADC model: acknowledges a pending request and queues the code the DAC must show.
  initial begin
    forever begin
      @(negedge sclk);
      if (rst && ack_en && adc_req) begin
        repeat (ack_delay - 1) @(negedge sclk);
        if (rst && adc_req) begin
          rsp_yk   = yk_tab[yk_idx];
          yk_idx   = (yk_idx + 1) % 4;
          adc_data = W'(rsp_yk);
          adc_ack  = 1'b1;
          q.push_back(exp_code(force_en ? force_val : 3 * (int'(rk_in) - rsp_yk)));
          @(negedge sclk);
          adc_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: samples after inputs settle, so valid&ready here means accepted next edge.
  int          cyc     = 0;
  int          last_en = -1;
  logic        en_prev = 1'b0;
  logic        hold_v  = 1'b0;
  logic [DW-1:0] held  = '0;

  initial begin
    forever begin
      @(negedge sclk);
      #1;
      cyc++;
      if (!rst) begin
        hold_v  = 1'b0;
        en_prev = 1'b0;
        last_en = -1;
      end else begin
        if (dac_valid) begin
          if (hold_v) check("dac_stable", dac_data, held);
          held   = dac_data;
          hold_v = !dac_ready;
          if (dac_ready) begin
            hs_count++;
            if (q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL dac_unexpected: got code %0d with nothing expected", dac_data);
            end else begin
              check("dac_data", dac_data, q.pop_front());
            end
          end
        end else begin
          hold_v = 1'b0;
        end
        if (pid_en) begin
          check("pid_en_pulse", en_prev, 0);
          en_count++;
          if (period_chk && last_en >= 0) check("pid_en_period", cyc - last_en, DIV);
          last_en = cyc;
        end
        if (!period_chk) last_en = -1;
        en_prev = pid_en;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    int reqs;

    // Reset state
    repeat (3) @(negedge sclk);
    check("rst_adc_req", adc_req, 0);
    check("rst_pid_en", pid_en, 0);
    check("rst_pid_clr", pid_clr, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_dac_data", dac_data, 2048);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    check("rst_pid_yk", pid_yk, 0);

    // Normal sampling with varying yk
    rst = 1'b1;
    run = 1'b1;
    period_chk = 1'b1;
    repeat (4) wait_hs(40);
    check("t1_en_count", en_count, 4);

    // Saturation corners
    force_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      force_val = force_tab[i];
      wait_hs(40);
    end
    force_en   = 1'b0;
    period_chk = 1'b0;

    // ADC never answers
    ack_en = 1'b0;
    e0 = en_count;
    wait_req(40);
    n = 0;
    while (adc_req && n < 400) begin
      n++;
      @(negedge sclk);
    end
    check("t3_req_cycles", n, TMO);
    check("t3_timeout", timeout, 1);
    check("t3_overrun", overrun, 1);
    check("t3_no_pid_en", en_count, e0);
    check("t3_busy", busy, 0);
    ack_en = 1'b1;
    wait_hs(40);

    // run rising edge clears flags and pulses pid_clr
    run = 1'b0;
    repeat (3) @(negedge sclk);
    run = 1'b1;
    @(negedge sclk);
    check("t6_pid_clr_hi", pid_clr, 1);
    check("t6_overrun_clr", overrun, 0);
    check("t6_timeout_clr", timeout, 0);
    @(negedge sclk);
    check("t6_pid_clr_lo", pid_clr, 0);

    // DAC back-pressure
    wait_hs(40);
    dac_ready = 1'b0;
    e0 = en_count;
    repeat (40) @(negedge sclk);
    check("t4_one_pid_en", en_count, e0 + 1);
    check("t4_overrun", overrun, 1);
    check("t4_dac_valid", dac_valid, 1);
    check("t4_pending", q.size(), 1);
    dac_ready = 1'b1;
    wait_hs(5);

    // run falls during STEP: sample completes, nothing new starts
    wait_en(40);
    run = 1'b0;
    wait_hs(10);
    reqs = 0;
    repeat (50) begin
      @(negedge sclk);
      if (adc_req) reqs++;
    end
    check("t6_no_req", reqs, 0);
    check("t6_idle", busy, 0);

    // Asynchronous reset during ADC_WAIT
    run = 1'b1;
    ack_en = 1'b0;
    wait_req(40);
    repeat (2) @(negedge sclk);
    check("t5_busy_before", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_adc_req_async", adc_req, 0);
    check("t5_busy", busy, 0);
    check("t5_dac_data", dac_data, 2048);
    check("t5_dac_valid", dac_valid, 0);
    @(negedge sclk);
    ack_en = 1'b1;
    rst = 1'b1;
    n = 0;
    while (!adc_req && n < 40) begin
      @(negedge sclk);
      n++;
      if (n == 1) check("t5_pid_clr", pid_clr, 1);
    end
    check("t5_first_tick", n, DIV);
    wait_hs(20);

    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
